// File: rtl/pacman_dir_ctrl_pkg.sv
// Shared types and helpers for the Pac-Man direction controller.
// Direction codes double as key indices: keys[UP] .. keys[RIGHT].
package pacman_pkg;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic [1:0] {IDLE_ST = 2'd0, RUN_ST = 2'd1, STOP_ST = 2'd2} state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int CMD_W = 11;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  // Speeds are in 1/FIXED_POINT_MULTIPLIER pixel per frame, sign-extended to CMD_W.
  function automatic logic signed [CMD_W-1:0] speed_x(input dir_t d, input int spd);
    logic signed [CMD_W-1:0] mag;
    mag = CMD_W'(spd);
    case (d)
      LEFT:    return -mag;
      RIGHT:   return mag;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [CMD_W-1:0] speed_y(input dir_t d, input int spd);
    logic signed [CMD_W-1:0] mag;
    mag = CMD_W'(spd);
    case (d)
      UP:      return -mag;
      DOWN:    return mag;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pacman_dir_ctrl_if.sv
// Signal bundle between keypad/mover side and the direction controller.
// speed_load is a one-clk strobe with no back-pressure: the mover must latch
// Xspeed_cmd/Yspeed_cmd on every cycle speed_load is high; commands hold otherwise.
interface pacman_dir_ctrl_if;
  import pacman_pkg::*;

  logic               startOfFrame;
  logic               key_up;
  logic               key_down;
  logic               key_left;
  logic               key_right;
  logic               wall_hit;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic signed [10:0] Xspeed_cmd;
  logic signed [10:0] Yspeed_cmd;
  logic               speed_load;
  logic [1:0]         cur_dir;
  logic               moving;
  logic               pending_valid;
  state_t             dbg_state;

  modport master (
    input  startOfFrame, key_up, key_down, key_left, key_right, wall_hit, topLeftX, topLeftY,
    output Xspeed_cmd, Yspeed_cmd, speed_load, cur_dir, moving, pending_valid, dbg_state
  );

  modport slave (
    output startOfFrame, key_up, key_down, key_left, key_right, wall_hit, topLeftX, topLeftY,
    input  Xspeed_cmd, Yspeed_cmd, speed_load, cur_dir, moving, pending_valid, dbg_state
  );

endinterface

// File: rtl/pacman_dir_ctrl_key_edge_prio.sv
// Rising-edge detector on the four arrow keys with UP > DOWN > LEFT > RIGHT priority.
module key_edge_prio
  import pacman_pkg::*;
(
   input  logic       clk,
   input  logic       resetN,
   input  logic [3:0] keys,
   output logic       req_valid,
   output dir_t       req_dir
);

   logic [3:0] keys_d;
   logic [3:0] rise;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) keys_d <= '0;
      else         keys_d <= keys;
   end

   assign rise = keys & ~keys_d;

   always_comb begin
      req_valid = |rise;
      req_dir   = UP;
      if      (rise[UP])    req_dir = UP;
      else if (rise[DOWN])  req_dir = DOWN;
      else if (rise[LEFT])  req_dir = LEFT;
      else if (rise[RIGHT]) req_dir = RIGHT;
   end

endmodule

// File: rtl/pacman_dir_ctrl.sv
// Turn/direction controller: buffers key turns until tile-aligned, reverses at once, stops on walls.
// Optional PACMAN_PENDING_TIMEOUT_EN discards a buffered turn after PENDING_FRAMES frames.
module pacman_dir_ctrl
   import pacman_pkg::*;
#(
   parameter int   TILE_SIZE      = 16,
   parameter int   SPEED          = 60,
`ifdef PACMAN_PENDING_TIMEOUT_EN
   parameter int   PENDING_FRAMES = 8,
`endif
   parameter dir_t INITIAL_DIR    = LEFT
)(
   input logic               clk,
   input logic               resetN,
   pacman_dir_ctrl_if.master bus
);

   localparam int TILE_BITS = $clog2(TILE_SIZE);

   state_t             state;
   dir_t               cur_dir;
   dir_t               pending_dir;
   logic               pending_valid;
   logic               hit_latch;
   logic signed [10:0] x_cmd;
   logic signed [10:0] y_cmd;
   logic               speed_load;
   logic               req_valid;
   dir_t               req_dir;
   logic               aligned;
   logic               stop_now;
   logic               apply_now;

`ifdef PACMAN_PENDING_TIMEOUT_EN
   localparam int CNT_W = $clog2(PENDING_FRAMES + 1);
   logic [CNT_W-1:0] pend_cnt;
`endif

   key_edge_prio u_keys (
      .clk       (clk),
      .resetN    (resetN),
      .keys      ({bus.key_right, bus.key_left, bus.key_down, bus.key_up}),
      .req_valid (req_valid),
      .req_dir   (req_dir)
   );

   // Low bits only, so negative two's-complement coordinates align correctly too.
   assign aligned = (bus.topLeftX[TILE_BITS-1:0] == '0) && (bus.topLeftY[TILE_BITS-1:0] == '0);

   always_comb begin
      stop_now  = 1'b0;
      apply_now = 1'b0;
      if (bus.startOfFrame) begin
         case (state)
            RUN_ST: begin
               if (hit_latch || bus.wall_hit)
                  stop_now = 1'b1;
               else if (pending_valid && (pending_dir == opposite(cur_dir) || aligned))
                  apply_now = 1'b1;
            end
            STOP_ST: apply_now = pending_valid;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= IDLE_ST;
         cur_dir       <= INITIAL_DIR;
         pending_dir   <= UP;
         pending_valid <= 1'b0;
         hit_latch     <= 1'b0;
         x_cmd         <= '0;
         y_cmd         <= '0;
         speed_load    <= 1'b0;
`ifdef PACMAN_PENDING_TIMEOUT_EN
         pend_cnt      <= '0;
`endif
      end else begin
         speed_load <= 1'b0;

         if (bus.startOfFrame)                   hit_latch <= 1'b0;
         else if (state == RUN_ST && bus.wall_hit) hit_latch <= 1'b1;

         case (state)
            IDLE_ST: begin
               if (bus.startOfFrame) begin
                  state      <= RUN_ST;
                  cur_dir    <= INITIAL_DIR;
                  x_cmd      <= speed_x(INITIAL_DIR, SPEED);
                  y_cmd      <= speed_y(INITIAL_DIR, SPEED);
                  speed_load <= 1'b1;
               end
            end
            RUN_ST, STOP_ST: begin
               if (stop_now) begin
                  state      <= STOP_ST;
                  x_cmd      <= '0;
                  y_cmd      <= '0;
                  speed_load <= 1'b1;
               end else if (apply_now) begin
                  state      <= RUN_ST;
                  cur_dir    <= pending_dir;
                  x_cmd      <= speed_x(pending_dir, SPEED);
                  y_cmd      <= speed_y(pending_dir, SPEED);
                  speed_load <= 1'b1;
               end
            end
            default: state <= IDLE_ST;
         endcase

         // A fresh key edge outranks consumption of the previous turn.
         if (req_valid) begin
            pending_dir   <= req_dir;
            pending_valid <= 1'b1;
`ifdef PACMAN_PENDING_TIMEOUT_EN
            pend_cnt      <= CNT_W'(PENDING_FRAMES);
`endif
         end else if (apply_now) begin
            pending_valid <= 1'b0;
         end
`ifdef PACMAN_PENDING_TIMEOUT_EN
         else if (bus.startOfFrame && pending_valid) begin
            if (pend_cnt <= CNT_W'(1)) begin
               pending_valid <= 1'b0;
               pend_cnt      <= '0;
            end else begin
               pend_cnt <= pend_cnt - 1'b1;
            end
         end
`endif
      end
   end

   assign bus.Xspeed_cmd    = x_cmd;
   assign bus.Yspeed_cmd    = y_cmd;
   assign bus.speed_load    = speed_load;
   assign bus.cur_dir       = cur_dir;
   assign bus.moving        = (state == RUN_ST);
   assign bus.pending_valid = pending_valid;
   assign bus.dbg_state     = state;

endmodule
